// File: rtl/pdm_sample_sequencer_if.sv
// -----------------------------------------------------------------------------
// pdm_sample_sequencer_if
// Sample stream feeding the PDM sample sequencer.
//   s_valid  producer has a sample on s_data
//   s_ready  sequencer FIFO can take a sample this cycle
//   s_data   N-bit unsigned sample (offset binary, midscale 2^(N-1))
// Handshake: a sample transfers on every rising clk edge where s_valid and
// s_ready are both 1. s_ready does not depend on s_valid; the producer may
// raise s_valid at any time and must hold s_data stable until the transfer.
// -----------------------------------------------------------------------------
interface pdm_sample_sequencer_if #(
  parameter int N = 16
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/pdm_sample_sequencer.sv
// -----------------------------------------------------------------------------
// pdm_sample_sequencer
// Feeds the N-bit level input of a first-order PDM modulator at a fixed sample
// rate. Samples arrive on a valid/ready stream into a DEPTH-entry FIFO and one
// is released every DIV clocks. When the FIFO runs dry or the block is
// disabled, the level is ramped to midscale so the PDM output stays click-free.
//
// Ports
//   clk           clock
//   rst_n         synchronous active-low reset
//   enable        run request
//   s_if          sample stream (slave modport: s_valid, s_ready, s_data)
//   pdm_level     registered level to the modulator
//   level_update  1-cycle pulse after every tick where pdm_level was written
//   underrun      sticky flag: FIFO was empty at a RUN tick
//   fifo_count    entries held in the FIFO
//   state         0 IDLE, 1 RUN, 2 UNDERRUN, 3 FADE
// -----------------------------------------------------------------------------
module pdm_sample_sequencer #(
  parameter int             N         = 16,
  parameter int             DIV       = 256,
  parameter int             DEPTH     = 4,
  parameter logic [N-1:0]   RAMP_STEP = 16'h0100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  pdm_sample_sequencer_if.slave     s_if,
  output logic [N-1:0]              pdm_level,
  output logic                      level_update,
  output logic                      underrun,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [1:0]                state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_UNDERRUN = 2'd2;
  localparam logic [1:0] ST_FADE     = 2'd3;

  localparam logic [N-1:0]     MID      = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0]    HALF     = CW'(DEPTH / 2);
  localparam logic [CW-1:0]    FULL     = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  // ---------------------------------------------------------------------------
  // Ramp one step toward midscale. Done in N+1 bits so the distance to MID is
  // never misread through a wrap; a step that would cross MID lands on MID.
  // ---------------------------------------------------------------------------
  function automatic logic [N-1:0] ramp_to_mid(input logic [N-1:0] lv);
    logic [N:0] l_w;
    logic [N:0] m_w;
    logic [N:0] s_w;
    logic [N:0] d_w;
    logic [N-1:0] r;
    l_w = {1'b0, lv};
    m_w = {1'b0, MID};
    s_w = {1'b0, RAMP_STEP};
    if (l_w >= m_w) begin
      d_w = l_w - m_w;
      r   = (d_w <= s_w) ? MID : (lv - RAMP_STEP);
    end else begin
      d_w = m_w - l_w;
      r   = (d_w <= s_w) ? MID : (lv + RAMP_STEP);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and handshake
  // ---------------------------------------------------------------------------
  logic [N-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic             tick;
  logic             push;
  logic             pop;
  logic             flush;
  logic [1:0]       state_nxt;
  logic [N-1:0]     level_nxt;
  logic             underrun_nxt;
  logic [N-1:0]     ramp_level;
  logic [N-1:0]     head;

  assign s_if.s_ready = (fifo_count < FULL) && (state != ST_FADE);
  assign push         = s_if.s_valid && s_if.s_ready;
  assign tick         = (state != ST_IDLE) && (cnt == CNT_LAST);
  assign head         = mem[rd_ptr];
  assign ramp_level   = ramp_to_mid(pdm_level);

  // ---------------------------------------------------------------------------
  // Sequencing. Dropping enable wins over a tick in the same cycle: the block
  // goes to FADE and nothing is popped. Pops only read entries present before
  // this cycle, so a same-cycle push never feeds the level directly.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    level_nxt    = pdm_level;
    underrun_nxt = underrun;
    pop          = 1'b0;
    flush        = 1'b0;
    case (state)
      ST_IDLE: begin
        level_nxt = MID;
        if (enable && (fifo_count >= HALF)) begin
          state_nxt    = ST_RUN;
          underrun_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt = ST_FADE;
          flush     = 1'b1;
        end else if (tick) begin
          if (fifo_count != '0) begin
            pop       = 1'b1;
            level_nxt = head;
          end else begin
            // Level is held on the tick that discovers the underrun.
            state_nxt    = ST_UNDERRUN;
            underrun_nxt = 1'b1;
          end
        end
      end
      ST_UNDERRUN: begin
        if (!enable) begin
          state_nxt = ST_FADE;
          flush     = 1'b1;
        end else if (tick) begin
          if (fifo_count >= HALF) begin
            pop       = 1'b1;
            level_nxt = head;
            state_nxt = ST_RUN;
          end else begin
            level_nxt = ramp_level;
          end
        end
      end
      default: begin // ST_FADE
        if (tick) begin
          level_nxt = ramp_level;
          // Leave on the tick that lands the level on midscale.
          if (ramp_level == MID) begin
            state_nxt = ST_IDLE;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pdm_level    <= MID;
      level_update <= 1'b0;
      underrun     <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      pdm_level    <= level_nxt;
      level_update <= tick;
      underrun     <= underrun_nxt;
      // Counter rests at 0 in IDLE and restarts from 0 on entry to RUN.
      if ((state == ST_IDLE) || (state_nxt == ST_IDLE)) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy. A flush (entry to FADE) discards everything,
  // including a push landing in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sample storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem[wr_ptr] <= s_if.s_data;
    end
  end

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pdm_sample_sequencer
// Bench for pdm_sample_sequencer with N=16, DIV=4, DEPTH=4, RAMP_STEP=16'h1000.
// A queue-based behavioural model tracks the expected outputs and is compared
// against the DUT on every falling edge; directed scenarios add literal
// expectations, followed by randomized stimulus.
// -----------------------------------------------------------------------------
module tb_pdm_sample_sequencer;

  localparam int           N     = 16;
  localparam int           DIV   = 4;
  localparam int           DEPTH = 4;
  localparam logic [15:0]  STEP  = 16'h1000;
  localparam int           MID   = 32'h8000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  pdm_sample_sequencer_if #(.N(N)) s_if ();

  logic [N-1:0] pdm_level;
  logic         level_update;
  logic         underrun;
  logic [2:0]   fifo_count;
  logic [1:0]   state;

  pdm_sample_sequencer #(
    .N(N), .DIV(DIV), .DEPTH(DEPTH), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .s_if(s_if.slave),
    .pdm_level(pdm_level),
    .level_update(level_update),
    .underrun(underrun),
    .fifo_count(fifo_count),
    .state(state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  exp_q[$];
  int  m_level = MID;
  int  m_mode = 0;      // 0 idle, 1 run, 2 underrun, 3 fade
  int  m_phase = 0;     // clocks since the last tick
  bit  m_under = 0;
  bit  m_upd = 0;
  bit  m_live = 0;

  function automatic int ramp(input int lv);
    int d;
    d = lv - MID;
    if (d >= -int'(STEP) && d <= int'(STEP)) return MID;
    if (d > 0) return lv - int'(STEP);
    return lv + int'(STEP);
  endfunction

  always @(posedge clk) begin
    bit t, pu, po, fl;
    int nxt;
    if (!rst_n) begin
      exp_q.delete();
      m_level = MID; m_mode = 0; m_phase = 0; m_under = 0; m_upd = 0;
      m_live = 1;
    end else begin
      t   = (m_mode != 0) && (m_phase == DIV - 1);
      pu  = s_if.s_valid && (exp_q.size() < DEPTH) && (m_mode != 3);
      po  = 0;
      fl  = 0;
      nxt = m_mode;
      case (m_mode)
        0: begin
          m_level = MID;
          if (enable && exp_q.size() >= DEPTH / 2) begin nxt = 1; m_under = 0; end
        end
        1: begin
          if (!enable) begin nxt = 3; fl = 1; end
          else if (t) begin
            if (exp_q.size() > 0) po = 1;
            else begin nxt = 2; m_under = 1; end
          end
        end
        2: begin
          if (!enable) begin nxt = 3; fl = 1; end
          else if (t) begin
            if (exp_q.size() >= DEPTH / 2) begin po = 1; nxt = 1; end
            else m_level = ramp(m_level);
          end
        end
        default: begin
          if (t) begin
            m_level = ramp(m_level);
            if (m_level == MID) nxt = 0;
          end
        end
      endcase
      if (po) m_level = exp_q.pop_front();
      if (fl) exp_q.delete();
      else if (pu) exp_q.push_back(int'(s_if.s_data));
      m_phase = (m_mode == 0 || nxt == 0) ? 0 : (m_phase + 1) % DIV;
      m_upd   = t;
      m_mode  = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("pdm_level", pdm_level, m_level);
      check("level_update", level_update, m_upd);
      check("underrun", underrun, m_under);
      check("fifo_count", fifo_count, exp_q.size());
      check("state", state, m_mode);
      check("s_ready", s_if.s_ready, (exp_q.size() < DEPTH) && (m_mode != 3));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_one(input logic [15:0] d);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    @(negedge clk);
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_update(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!level_update && waited < budget);
    if (!level_update) begin
      n_checks++;
      n_errors++;
      $display("FAIL update_timeout: got no pulse within %0d clocks expected a pulse", budget);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int w;
    w = 0;
    while (state !== s && w < budget) begin
      @(negedge clk);
      w++;
    end
    check("wait_state", state, s);
  endtask

  task automatic check_reset_values();
    check("rst_level", pdm_level, 32'h8000);
    check("rst_state", state, 0);
    check("rst_ready", s_if.s_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_underrun", underrun, 0);
    check("rst_update", level_update, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int vprob;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    // Case 1: reset values
    rst_n = 1'b0;
    cyc(2);
    check_reset_values();
    rst_n = 1'b1;

    // Case 2: two samples, enable, paced release
    push_one(16'h1000);
    push_one(16'h2000);
    enable = 1'b1;
    wait_update(20, w);
    check("c2_first_level", pdm_level, 32'h1000);
    check("c2_first_delay", w, 5);
    check("c2_state", state, 1);
    wait_update(20, w);
    check("c2_second_level", pdm_level, 32'h2000);
    check("c2_spacing", w, 4);

    // Case 3: underrun, hold, ramp, recovery
    wait_update(20, w);
    check("c3_spacing", w, 4);
    check("c3_state", state, 2);
    check("c3_underrun", underrun, 1);
    check("c3_hold", pdm_level, 32'h2000);
    for (int k = 1; k <= 6; k++) begin
      wait_update(20, w);
      check("c3_ramp", pdm_level, 32'h2000 + k * 32'h1000);
    end
    push_one(16'h4321);
    push_one(16'h5678);
    wait_update(20, w);
    check("c3_recover_level", pdm_level, 32'h4321);
    check("c3_recover_state", state, 1);
    check("c3_sticky", underrun, 1);
    enable = 1'b0;
    wait_state(2'd0, 100);

    // Case 4: full FIFO refuses, accepts after a pop
    push_one(16'hA000);
    push_one(16'hB000);
    push_one(16'hC000);
    push_one(16'hD000);
    check("c4_count_full", fifo_count, 4);
    check("c4_ready_low", s_if.s_ready, 0);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 16'h0E0E;
    cyc(10);
    check("c4_not_accepted", fifo_count, 4);
    enable = 1'b1;
    wait_update(20, w);
    check("c4_pop_level", pdm_level, 32'hA000);
    check("c4_after_pop", fifo_count, 3);
    cyc(1);
    s_if.s_valid = 1'b0;
    check("c4_accepted", fifo_count, 4);
    enable = 1'b0;
    wait_state(2'd0, 200);

    // Case 5: fade from F000 with samples queued
    push_one(16'hF000);
    push_one(16'h0101);
    push_one(16'h0202);
    push_one(16'h0303);
    enable = 1'b1;
    wait_update(20, w);
    check("c5_level", pdm_level, 32'hF000);
    check("c5_count", fifo_count, 3);
    enable = 1'b0;
    cyc(1);
    check("c5_state_fade", state, 3);
    check("c5_flushed", fifo_count, 0);
    check("c5_ready_low", s_if.s_ready, 0);
    for (int k = 1; k <= 7; k++) begin
      wait_update(20, w);
      check("c5_ramp", pdm_level, 32'hF000 - k * 32'h1000);
    end
    check("c5_idle", state, 0);
    check("c5_ready_back", s_if.s_ready, 1);

    // Case 6: reset mid-RUN
    push_one(16'h1234);
    push_one(16'h0011);
    push_one(16'h0022);
    push_one(16'h0033);
    enable = 1'b1;
    wait_update(20, w);
    check("c6_level", pdm_level, 32'h1234);
    check("c6_count", fifo_count, 3);
    rst_n = 1'b0;
    cyc(1);
    check_reset_values();
    rst_n  = 1'b1;
    enable = 1'b0;
    cyc(2);

    // Randomized traffic: push density changes per segment
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 3))
        0:       vprob = 5;
        1:       vprob = 20;
        2:       vprob = 50;
        default: vprob = 90;
      endcase
      for (int c = 0; c < 150; c++) begin
        s_if.s_valid = ($urandom_range(0, 99) < vprob);
        s_if.s_data  = 16'($urandom);
        if ($urandom_range(0, 29) == 0) enable = ~enable;
        rst_n = ($urandom_range(0, 599) != 0);
        @(negedge clk);
      end
    end
    s_if.s_valid = 1'b0;
    rst_n = 1'b1;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
